iq_symbol_fifo: RTL and testbench

Single-clock, first-word-fall-through FIFO that buffers 64-QAM I/Q symbol pairs between the symbol mapper and the downstream pulse-shaping/DAC stage. Captures one 4-bit I and one 4-bit Q sample on every mapper `new_symbol` pulse and presents them through a valid/ready read port. Drives the mapper's full back-pressure input. Provides occupancy and sticky error flags for debug.

---
 rtl/qam64_pkg.sv | 16 +
 rtl/iq_symbol_fifo_if.sv | 57 +++++
 rtl/iq_fifo_mem.sv | 25 ++
 rtl/iq_symbol_fifo.sv | 84 ++++++++
 tb/tb_iq_symbol_fifo.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qam64_pkg.sv
// Shared 64-QAM symbol types used by the mapper and the I/Q symbol FIFO.
// A legal 4-bit level is odd: +-1, +-3, +-5, +-7 in two's complement.
package qam64_pkg;

  localparam int SYM_W = 4;

  typedef struct packed {
    logic [SYM_W-1:0] i;
    logic [SYM_W-1:0] q;
  } iq_sym_t;

  function automatic logic is_legal_level(logic [SYM_W-1:0] v);
    return v[0];
  endfunction

endpackage

// File: rtl/iq_symbol_fifo_if.sv
// Mapper-side write port, consumer-side read port and debug status
// of the I/Q symbol FIFO.
interface iq_symbol_fifo_if
  import qam64_pkg::*;
#(
  parameter int DEPTH = 16
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clear;
  logic             wr_en;
  logic [SYM_W-1:0] wr_i;
  logic [SYM_W-1:0] wr_q;
  logic             full;
  logic             almost_full;
  logic             rd_valid;
  logic             rd_ready;
  logic [SYM_W-1:0] rd_i;
  logic [SYM_W-1:0] rd_q;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             sym_err;

  modport slave (
    input  clear,
    input  wr_en,
    input  wr_i,
    input  wr_q,
    input  rd_ready,
    output full,
    output almost_full,
    output rd_valid,
    output rd_i,
    output rd_q,
    output level,
    output overflow,
    output sym_err
  );

  modport master (
    output clear,
    output wr_en,
    output wr_i,
    output wr_q,
    output rd_ready,
    input  full,
    input  almost_full,
    input  rd_valid,
    input  rd_i,
    input  rd_q,
    input  level,
    input  overflow,
    input  sym_err
  );

endinterface

// File: rtl/iq_fifo_mem.sv
// DEPTH x 8 I/Q register file: synchronous write, asynchronous read.
// No reset; validity of entries is tracked by the FIFO control.
module iq_fifo_mem
  import qam64_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  iq_sym_t       wdata,
  input  logic [AW-1:0] raddr,
  output iq_sym_t       rdata
);

  iq_sym_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/iq_symbol_fifo.sv
// First-word-fall-through FIFO between the 64-QAM mapper and the
// pulse-shaping/DAC stage, with occupancy and sticky debug flags.
module iq_symbol_fifo
  import qam64_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 14
) (
  input  logic              data_clk,
  input  logic              rst_n,
  iq_symbol_fifo_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [LW-1:0] lvl_q;
  logic          ovf_q;
  logic          err_q;
  logic          wr_acc;
  logic          rd_acc;
  logic          bad_sym;
  iq_sym_t       wdata;
  iq_sym_t       head;

  assign bus.full        = (lvl_q == LW'(DEPTH));
  assign bus.almost_full = (lvl_q >= LW'(AFULL_THRESH));
  assign bus.rd_valid    = (lvl_q != '0);

  // Read does not free space for a same-cycle write when full.
  assign wr_acc  = bus.wr_en && !bus.full && !bus.clear;
  assign rd_acc  = bus.rd_valid && bus.rd_ready && !bus.clear;
  assign bad_sym = !is_legal_level(bus.wr_i) ||
                   !is_legal_level(bus.wr_q);

  assign wdata.i = bus.wr_i;
  assign wdata.q = bus.wr_q;

  iq_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (data_clk),
    .we    (wr_acc),
    .waddr (wp_q),
    .wdata (wdata),
    .raddr (rp_q),
    .rdata (head)
  );

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.clear) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (wr_acc) wp_q <= wp_q + 1'b1;
      if (rd_acc) rp_q <= rp_q + 1'b1;
      if (bus.wr_en && bus.full) ovf_q <= 1'b1;
      if (wr_acc && bad_sym) err_q <= 1'b1;
      unique case (1'b1)
        wr_acc && !rd_acc: lvl_q <= lvl_q + 1'b1;
        rd_acc && !wr_acc: lvl_q <= lvl_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.rd_i     = bus.rd_valid ? head.i : '0;
  assign bus.rd_q     = bus.rd_valid ? head.q : '0;
  assign bus.level    = lvl_q;
  assign bus.overflow = ovf_q;
  assign bus.sym_err  = err_q;

endmodule

// File: tb/tb_iq_symbol_fifo.sv
// Scoreboard bench for iq_symbol_fifo: fill/drain, overflow, streaming,
// symbol error, clear and asynchronous reset scenarios.
module tb_iq_symbol_fifo;
  import qam64_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFT   = 14;

  logic data_clk = 1'b0;
  logic rst_n    = 1'b0;

  iq_symbol_fifo_if #(.DEPTH(DEPTH)) bus ();

  iq_symbol_fifo #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFT)
  ) dut (
    .data_clk (data_clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 data_clk = ~data_clk;

  int      n_cmp = 0;
  int      n_err = 0;
  int      mlevel = 0;
  iq_sym_t sb[$];

  task automatic drive(input bit we, input logic [3:0] i,
                       input logic [3:0] q, input bit rr,
                       input bit clr = 1'b0);
    bit wacc;
    bit racc;
    iq_sym_t s;
    bus.wr_en    = we;
    bus.wr_i     = i;
    bus.wr_q     = q;
    bus.rd_ready = rr;
    bus.clear    = clr;
    @(posedge data_clk);
    wacc = we && (mlevel != DEPTH) && !clr;
    racc = (mlevel != 0) && rr && !clr;
    if (clr) begin
      sb.delete();
      mlevel = 0;
    end else begin
      if (racc) void'(sb.pop_front());
      if (wacc) begin
        s.i = i;
        s.q = q;
        sb.push_back(s);
      end
      mlevel = mlevel + int'(wacc) - int'(racc);
    end
    @(negedge data_clk);
    bus.wr_en    = 1'b0;
    bus.rd_ready = 1'b0;
    bus.clear    = 1'b0;
  endtask

  function automatic logic [3:0] rnd_odd();
    logic [3:0] v;
    v = {3'($urandom_range(0, 7)), 1'b1};
    return v;
  endfunction

  task automatic test_reset();
    n_cmp++;
    if (bus.level !== '0 || bus.rd_valid !== 1'b0 ||
        bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status got lvl=%0d v=%b f=%b af=%b want 0 0 0 0",
               bus.level, bus.rd_valid, bus.full, bus.almost_full);
    end
    n_cmp++;
    if (bus.rd_i !== 4'd0 || bus.rd_q !== 4'd0 ||
        bus.overflow !== 1'b0 || bus.sym_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data got i=%h q=%h ovf=%b err=%b want 0 0 0 0",
               bus.rd_i, bus.rd_q, bus.overflow, bus.sym_err);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 4'd3, 4'b1001, 1'b0);
    n_cmp++;
    if (bus.rd_valid !== 1'b1 || bus.rd_i !== 4'd3 ||
        bus.rd_q !== 4'd9 || bus.level !== 5'd1) begin
      n_err++;
      $display("FAIL single_wr got v=%b i=%0d q=%0d lvl=%0d want 1 3 9 1",
               bus.rd_valid, bus.rd_i, bus.rd_q, bus.level);
    end
    drive(1'b0, 4'd0, 4'd0, 1'b1);
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_i !== 4'd0 ||
        bus.rd_q !== 4'd0 || bus.level !== 5'd0) begin
      n_err++;
      $display("FAIL single_rd got v=%b i=%0d q=%0d lvl=%0d want 0 0 0 0",
               bus.rd_valid, bus.rd_i, bus.rd_q, bus.level);
    end
  endtask

  task automatic test_drain(input string tag);
    while (sb.size() > 0) begin
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.rd_i !== sb[0].i ||
          bus.rd_q !== sb[0].q) begin
        n_err++;
        $display("FAIL %s_data got v=%b i=%h q=%h want 1 %h %h",
                 tag, bus.rd_valid, bus.rd_i, bus.rd_q, sb[0].i, sb[0].q);
      end
      drive(1'b0, 4'd0, 4'd0, 1'b1);
    end
    n_cmp++;
    if (bus.level !== 5'd0 || bus.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_empty got lvl=%0d v=%b want 0 0",
               tag, bus.level, bus.rd_valid);
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 4'((2 * k + 1) % 16), (k < 8) ? 4'd1 : 4'd3, 1'b0);
      n_cmp++;
      if (bus.level !== 5'(mlevel) ||
          bus.almost_full !== (mlevel >= AFT) ||
          bus.full !== (mlevel == DEPTH)) begin
        n_err++;
        $display("FAIL fill_flags got lvl=%0d af=%b f=%b want %0d %b %b",
                 bus.level, bus.almost_full, bus.full, mlevel,
                 mlevel >= AFT, mlevel == DEPTH);
      end
    end
    drive(1'b1, 4'd7, 4'd7, 1'b0);
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.level !== 5'd16 ||
        bus.sym_err !== 1'b0) begin
      n_err++;
      $display("FAIL overflow got ovf=%b lvl=%0d err=%b want 1 16 0",
               bus.overflow, bus.level, bus.sym_err);
    end
    test_drain("fill_drain");
  endtask

  task automatic test_full_rw();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear_ovf got %b want 0", bus.overflow);
    end
    for (int k = 0; k < DEPTH; k++) drive(1'b1, rnd_odd(), rnd_odd(), 1'b0);
    n_cmp++;
    if (bus.rd_i !== sb[0].i || bus.rd_q !== sb[0].q) begin
      n_err++;
      $display("FAIL full_rw_head got %h%h want %h%h",
               bus.rd_i, bus.rd_q, sb[0].i, sb[0].q);
    end
    drive(1'b1, 4'd5, 4'd5, 1'b1);
    n_cmp++;
    if (bus.level !== 5'd15 || bus.full !== 1'b0 ||
        bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL full_rw got lvl=%0d f=%b ovf=%b want 15 0 1",
               bus.level, bus.full, bus.overflow);
    end
    test_drain("full_rw");
  endtask

  task automatic test_stream();
    for (int k = 0; k < 5; k++) drive(1'b1, rnd_odd(), rnd_odd(), 1'b0);
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if (bus.rd_i !== sb[0].i || bus.rd_q !== sb[0].q) begin
        n_err++;
        $display("FAIL stream_data got %h%h want %h%h",
                 bus.rd_i, bus.rd_q, sb[0].i, sb[0].q);
      end
      drive(1'b1, rnd_odd(), rnd_odd(), 1'b1);
      n_cmp++;
      if (bus.level !== 5'd5) begin
        n_err++;
        $display("FAIL stream_level got %0d want 5", bus.level);
      end
    end
    test_drain("stream");
  endtask

  task automatic test_sym_err_clear();
    drive(1'b1, 4'b1111, 4'b1001, 1'b0);
    n_cmp++;
    if (bus.sym_err !== 1'b0) begin
      n_err++;
      $display("FAIL sym_legal got %b want 0", bus.sym_err);
    end
    drive(1'b1, 4'd4, 4'd1, 1'b0);
    n_cmp++;
    if (bus.sym_err !== 1'b1) begin
      n_err++;
      $display("FAIL sym_even got %b want 1", bus.sym_err);
    end
    drive(1'b1, 4'b1000, 4'd1, 1'b0);
    n_cmp++;
    if (bus.sym_err !== 1'b1 || bus.level !== 5'd3) begin
      n_err++;
      $display("FAIL sym_m8 got err=%b lvl=%0d want 1 3",
               bus.sym_err, bus.level);
    end
    drive(1'b1, 4'd1, 4'd1, 1'b0, 1'b1);
    n_cmp++;
    if (bus.level !== 5'd0 || bus.rd_valid !== 1'b0 ||
        bus.sym_err !== 1'b0 || bus.rd_i !== 4'd0) begin
      n_err++;
      $display("FAIL clear_wr got lvl=%0d v=%b err=%b i=%h want 0 0 0 0",
               bus.level, bus.rd_valid, bus.sym_err, bus.rd_i);
    end
    drive(1'b1, 4'b1000, 4'b0000, 1'b0);
    n_cmp++;
    if (bus.sym_err !== 1'b1) begin
      n_err++;
      $display("FAIL sym_q_even got %b want 1", bus.sym_err);
    end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 9; k++) drive(1'b1, rnd_odd(), rnd_odd(), 1'b0);
    drive(1'b1, 4'd2, 4'd2, 1'b0);
    bus.wr_en = 1'b1;
    bus.wr_i  = 4'd5;
    bus.wr_q  = 4'd6;
    n_cmp++;
    if (bus.level !== 5'd10 || bus.sym_err !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset got lvl=%0d err=%b want 10 1",
               bus.level, bus.sym_err);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.level !== '0 || bus.rd_valid !== 1'b0 ||
        bus.rd_i !== 4'd0 || bus.rd_q !== 4'd0 ||
        bus.sym_err !== 1'b0 || bus.almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst got lvl=%0d v=%b i=%h q=%h err=%b af=%b want 0",
               bus.level, bus.rd_valid, bus.rd_i, bus.rd_q,
               bus.sym_err, bus.almost_full);
    end
    bus.wr_en = 1'b0;
    sb.delete();
    mlevel = 0;
    @(negedge data_clk);
    @(negedge data_clk);
    n_cmp++;
    if (bus.level !== '0) begin
      n_err++;
      $display("FAIL rst_hold got lvl=%0d want 0", bus.level);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) drive(1'b1, rnd_odd(), rnd_odd(), 1'b0);
    test_drain("resume");
  endtask

  initial begin
    bus.clear    = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_i     = '0;
    bus.wr_q     = '0;
    bus.rd_ready = 1'b0;
    repeat (2) @(negedge data_clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge data_clk);
    test_single();
    test_fill_drain();
    test_full_rw();
    test_stream();
    test_sym_err_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
